// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes and FSM state encoding for the HI/LO multiply/divide unit
package mdu_pkg;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DIVU  = 3'd3;
  localparam logic [2:0] MTHI  = 3'd4;
  localparam logic [2:0] MTLO  = 3'd5;
  localparam logic [2:0] NOP   = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/hilo_result_regs.sv
// rtl/hilo_result_regs.sv - HI/LO register pair with independent writes and the S read mux
module hilo_result_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hi_we,
  input  logic [WIDTH-1:0] hi_d,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] lo_d,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] s
);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

  assign s = rd_hi ? hi : lo;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - fixed-latency MULT/DIV unit feeding HI/LO for the EX stage
// Divider present only when MDU_DIV_EN is defined; otherwise DIV/DIVU are no-ops.
module hilo_muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  input  logic             rd_hi,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] S
);
  import mdu_pkg::*;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_t           state, state_next;
  logic [CW-1:0]    count, load_cycles;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             long_op, load;
  logic             hi_we, lo_we;
  logic [WIDTH-1:0] hi_d, lo_d, res_hi, res_lo;
  logic             mul_signed;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    long_op     = 1'b0;
    load_cycles = CW'(MULT_CYCLES);
    if (op == MULT || op == MULTU) begin
      long_op = 1'b1;
    end
`ifdef MDU_DIV_EN
    else if (op == DIV || op == DIVU) begin
      long_op     = 1'b1;
      load_cycles = CW'(DIV_CYCLES);
    end
`endif
  end

  // Sign-extending into a 2*WIDTH product gives the signed result in the low bits.
  assign mul_signed = (op_q == MULT);
  assign prod = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q} *
                {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};

`ifdef MDU_DIV_EN
  logic             div_signed, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, divisor, quot, rem;

  // One unsigned divider on magnitudes; signs are restored afterwards.
  assign div_signed = (op_q == DIV);
  assign neg_a      = div_signed & a_q[WIDTH-1];
  assign neg_b      = div_signed & b_q[WIDTH-1];
  assign mag_a      = neg_a ? -a_q : a_q;
  assign mag_b      = neg_b ? -b_q : b_q;
  assign divisor    = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
  assign quot       = mag_a / divisor;
  assign rem        = mag_a % divisor;
`endif

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (op_q == DIV || op_q == DIVU) begin
      if (b_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_lo = (neg_a ^ neg_b) ? -quot : quot;
        res_hi = neg_a ? -rem : rem;
      end
    end
`endif
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = A;
    lo_d       = A;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          if (long_op) begin
            load       = 1'b1;
            state_next = BUSY;
          end else if (op == MTHI) begin
            hi_we = 1'b1;
          end else if (op == MTLO) begin
            lo_we = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (count == CW'(1)) begin
          state_next = IDLE;
          hi_we      = 1'b1;
          lo_we      = 1'b1;
          hi_d       = res_hi;
          lo_d       = res_lo;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        count <= load_cycles;
        op_q  <= op;
        a_q   <= A;
        b_q   <= B;
      end else if (state == BUSY) begin
        count <= (cancel || count == CW'(1)) ? '0 : count - CW'(1);
      end
    end
  end

  assign busy = (state == BUSY);

  hilo_result_regs #(.WIDTH(WIDTH)) u_regs (
    .clk   (clk),
    .reset (reset),
    .hi_we (hi_we),
    .hi_d  (hi_d),
    .lo_we (lo_we),
    .lo_d  (lo_d),
    .rd_hi (rd_hi),
    .hi    (HI),
    .lo    (LO),
    .s     (S)
  );

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised multiply/divide unit with integrated HI/LO result registers, serving the EX stage of the pipelined MIPS core. Accepts one operation per start pulse, holds `busy` for a fixed per-operation latency, and then commits results to HI/LO. Also executes MTHI/MTLO writes and presents HI or LO on a single read port for MFHI/MFLO. This block supersedes the fixed 32-bit, single-cycle HI/LO register pair.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width
- `MULT_CYCLES`, 5, busy cycles for MULT/MULTU (≥1)
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  operation request, qualified by `op`
- `op`  in  3  MULT, MULTU, DIV, DIVU, MTHI, MTLO (codes in package)
- `A`  in  WIDTH  rs operand; the source for MTHI/MTLO
- `B`  in  WIDTH  rt operand
- `cancel`  in  1  aborts in-flight operation (exception flush)
- `rd_hi`  in  1  read select: 1 = HI, 0 = LO
- `busy`  out  1  operation in flight
- `HI`  out  WIDTH  HI register
- `LO`  out  WIDTH  LO register
- `S`  out  WIDTH  `rd_hi ? HI : LO`, combinational

## Operation
- Reset: `HI`=0, `LO`=0, `busy`=0, counter=0, operand latches=0.
- States: IDLE and BUSY.
- IDLE + `start` + MULT/MULTU/DIV/DIVU:
  - capture `A`, `B` and `op`;
  - load the counter with `MULT_CYCLES` or `DIV_CYCLES`;
  - go to BUSY.
- IDLE + `start` + MTHI/MTLO: write `A` to HI or LO at that edge; stay IDLE.
- BUSY: decrement the counter each cycle. When the counter reaches 1, commit `{HI,LO}` at that edge and return to IDLE.
- Arithmetic:
  - MULT signed and MULTU unsigned, full 2·WIDTH product; HI = upper half, LO = lower half.
  - DIV signed: quotient truncates toward zero and goes to LO; remainder takes the dividend's sign and goes to HI.
  - DIVU unsigned: LO = quotient, HI = remainder.
- Boundary conditions:
  - Divide by zero, both signed and unsigned: LO = all ones, HI = captured A.
  - Signed overflow (A = most-negative value, B = −1): LO = most-negative value, HI = 0.
- `start` while BUSY: ignored; no capture and no restart. The pipeline stalls on `busy`, so this is an illegal-but-safe case.
- `cancel` while BUSY: go to IDLE next edge; HI/LO keep their pre-operation values; nothing is committed.
- `cancel` together with `start` in IDLE: the `start` is discarded (no capture, and no MTHI/MTLO write).
- `cancel` in IDLE without `start`: no effect.
- Reset mid-operation: everything returns to reset values; nothing is committed.
- Invalid `op` codes: treated as no-op.

## Timing
- Start accepted at the edge ending cycle T. `busy`=1 during cycles T+1 … T+N, where N is the configured latency.
- Results commit at the edge ending cycle T+N. `HI`/`LO` show the new values and `busy`=0 from cycle T+N+1.
- A back-to-back start is legal in cycle T+N+1.
- MTHI/MTLO: new value visible on `HI`/`LO`/`S` in the cycle after the start edge; `busy` is never asserted.
- `S` has zero latency from `rd_hi`, `HI` and `LO`.
- `busy` is a registered output.

## Configuration
- Macro `MDU_DIV_EN`.
- Defined: DIV/DIVU are implemented as described above.
- Undefined: no divider is synthesised. DIV/DIVU become no-ops: `busy` stays 0 and HI/LO are unchanged. The `DIV_CYCLES` parameter is unused.

## Structure
- Package `mdu_pkg`:
  - op code localparams (MULT, MULTU, DIV, DIVU, MTHI, MTLO, NOP);
  - state encoding (IDLE, BUSY).
- Sub-module `hilo_result_regs` holds HI/LO:
  - independent write enables and data;
  - synchronous reset to 0;
  - the `S` read mux.
- The top level holds the FSM, the counter, the operand latches and the arithmetic.

## Test plan
- MULT, A=0xFFFFFFFE (−2), B=3, MULT_CYCLES=5 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV, A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with B=0, A=0x12 → LO=0xFFFFFFFF, HI=0x12.
- MTHI, A=0xDEADBEEF, then `rd_hi`=1 → S=0xDEADBEEF next cycle, `busy` never asserted, LO unchanged.
- Preload HI/LO=0x1/0x2, start MULT, assert `cancel` in the 3rd busy cycle → `busy`=0 next cycle, HI/LO still 0x1/0x2. A second `start` issued while busy is ignored.
- `reset` in the middle of a DIV → all outputs 0 next cycle. Rebuild without `MDU_DIV_EN` and issue DIV → `busy` stays 0 and HI/LO unchanged.
